flash_spi_mem_ctrl: RTL and testbench
=====================================

Name: flash_spi_mem_ctrl

Overview:
- Parametrised successor to the byte-level SPI flash memory model, with configurable array depth, address length, page size, program time and JEDEC ID.
- Bytes arrive on D when qualified by DATA_DONE while chip select S is low. Command responses are returned on Q with a one-cycle valid strobe.
- Adds status/WIP tracking, page-wrapped program, bulk erase, a hardware write-protect input and busy lockout.
- Sits behind the SPI shifter as the command/array engine and is the drop-in model for flash benches.

Parameters:
- ADDR_BYTES, 3, number of address bytes after READ/PP; legal values 1..3; sent MSB first.
- DEPTH_LOG2, 12, array is 2**DEPTH_LOG2 bytes; upper address bits are ignored.
- PAGE_LOG2, 8, page size is 2**PAGE_LOG2 bytes; must be <= DEPTH_LOG2.
- PROG_CYCLES, 16, SCK cycles BUSY stays high after a page program.
- JEDEC_ID, 24'h20BA16, 3-byte identifier returned by RDID.

Ports:
- SCK  in  1  system clock; rising edge.
- RESET  in  1  asynchronous, active-low reset.
- S  in  1  chip select, active low; a rising edge terminates the transaction.
- W_ENABLE  in  1  hardware write enable; 0 blocks PP and BE.
- D  in  8  command/address/data byte.
- DATA_DONE  in  1  D holds a valid byte this cycle.
- Q  out  8  response byte.
- Q_VALID  out  1  Q is new this cycle; single-cycle pulse.
- BUSY  out  1  program/erase in progress; mirrors status WIP.

Behaviour:
- Opcodes match the shared memory parameter macros: WREN 06, WRDI 04, RDSR 05, RDID 9F, READ 03, PP 02, BE C7.
- Byte accept: at an SCK rise with S=0 and DATA_DONE=1. If S=1 and DATA_DONE=1 in the same cycle, S wins and the byte is dropped.
- Reset (async, RESET=0):
  - Q=00, Q_VALID=0, BUSY=0, WEL=0, state IDLE, address and counters 0.
  - Array contents are untouched.
  - Reset during program or erase aborts it; partially written bytes remain.
- States: IDLE, OPCODE, ADDR, READ_DATA, PROG_DATA, STATUS, ID, IGNORE, PROG_WAIT, ERASE.
- IDLE: S falling leads to OPCODE. Any cycle with S=1 returns to IDLE unless PROG_WAIT or ERASE is active.
- First accepted byte is the opcode. While BUSY=1 only RDSR is honoured; every other opcode goes to IGNORE.
- WREN/WRDI: set/clear WEL at the opcode byte; go to IGNORE.
- RDSR:
  - Each later accepted byte returns status on the next cycle, with Q_VALID=1.
  - Status = {6'b0, WEL, WIP}, sampled live.
- RDID: each later accepted byte returns JEDEC_ID[23:16], then [15:8], then [7:0], then 00 repeatedly.
- READ:
  - Collect ADDR_BYTES bytes MSB first; address is taken modulo 2**DEPTH_LOG2.
  - Each later accepted byte returns mem[addr] on the next cycle with Q_VALID.
  - Address increments and wraps from the top of the array to 0.
- PP:
  - Requires WEL=1 and W_ENABLE=1 at the opcode; otherwise goes to IGNORE.
  - After the address, each data byte is written as mem[addr] &= D (flash semantics: bits only clear).
  - Only the low PAGE_LOG2 address bits increment, so the address wraps within the page.
  - On S rising with at least one data byte written: BUSY=1 for exactly PROG_CYCLES cycles, then BUSY=0 and WEL=0.
  - With zero data bytes: no busy period, and WEL is retained.
- BE:
  - Requires WEL=1 and W_ENABLE=1.
  - Executes on the S rising edge with no bytes after the opcode; otherwise the command is ignored.
  - BUSY=1; one byte per cycle is set to FF from address 0 upward.
  - BUSY drops and WEL clears the cycle after the last byte; duration is 2**DEPTH_LOG2 cycles.
- Unknown opcode: go to IGNORE; all bytes are dropped until S=1.
- Q holds its last value between pulses.

Test Plan:
- Reset, then RDID with 4 dummy bytes -> Q_VALID pulses carrying 20, BA, 16, 00, each one cycle after its dummy byte.
- WREN; PP at 000010 with data 5A, 3C; S high -> BUSY high for 16 cycles; a concurrent RDSR returns 03 then 00; READ 000010 returns 5A, 3C.
- PP of 3 bytes at 0000FE (PAGE_LOG2=8) -> bytes land at 0FE, 0FF, 000; reprogramming 0FE with F0 over 5A yields 50.
- W_ENABLE=0: WREN, BE -> no BUSY, array unchanged. W_ENABLE=1: WREN, BE -> BUSY for 4096 cycles, READ 000FFF returns FF, RDSR returns 00.
- READ starting at 000FFF for 2 bytes -> returns mem[FFF], then mem[000]. Non-RDSR opcode while BUSY -> no Q_VALID.
- RESET low midway through the PP busy period -> BUSY=0 and Q=00 immediately; RDSR after release returns 00.

Source files
------------

// File: rtl/flash_spi_mem_ctrl_if.sv
// flash_spi_mem_ctrl_if: byte bus between the SPI shifter and the flash command engine
// Signals: S chip select (low active), W_ENABLE write protect, D/DATA_DONE byte in,
//          Q/Q_VALID response out, BUSY program/erase in progress
interface flash_spi_mem_ctrl_if;
  logic       S;
  logic       W_ENABLE;
  logic [7:0] D;
  logic       DATA_DONE;
  logic [7:0] Q;
  logic       Q_VALID;
  logic       BUSY;
  modport master (output S, W_ENABLE, D, DATA_DONE, input Q, Q_VALID, BUSY);
  modport slave (input S, W_ENABLE, D, DATA_DONE, output Q, Q_VALID, BUSY);
endinterface

// File: rtl/flash_spi_mem_ctrl.sv
// flash_spi_mem_ctrl: SPI flash command decoder and byte array with program/erase busy engine
// Ports: SCK clock (rising edge), RESET async active-low, bus slave modport:
//        S/W_ENABLE/D/DATA_DONE in, Q/Q_VALID/BUSY out
module flash_spi_mem_ctrl #(
  parameter int          ADDR_BYTES  = 3,
  parameter int          DEPTH_LOG2  = 12,
  parameter int          PAGE_LOG2   = 8,
  parameter int          PROG_CYCLES = 16,
  parameter logic [23:0] JEDEC_ID    = 24'h20BA16
) (
  input logic SCK,
  input logic RESET,
  flash_spi_mem_ctrl_if.slave bus
);
  typedef enum logic [3:0] {
    IDLE, OPCODE, ADDR, READ_DATA, PROG_DATA, STATUS, ID, IGNORE, PROG_WAIT, ERASE
  } state_t;
  localparam int AW = DEPTH_LOG2;
  localparam int CW = AW > $clog2(PROG_CYCLES + 1) ? AW : $clog2(PROG_CYCLES + 1);
  localparam logic [AW-1:0] PMASK = AW'((64'd1 << PAGE_LOG2) - 64'd1);
  logic [7:0] mem [2**AW];
  state_t cmd_q, cmd_d, bsy_q, bsy_d;
  logic [AW-1:0] addr_q, addr_d, wa;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] q_q, q_d, rd, wd;
  logic wel_q, wel_d, qv_q, qv_d, wrote_q, wrote_d, pp_q, pp_d, be_q, be_d;
  logic acc, busy, we;
  assign acc = !bus.S && bus.DATA_DONE;
  assign busy = bsy_q != IDLE;
  assign rd = mem[addr_q];
  assign bus.Q = q_q;
  assign bus.Q_VALID = qv_q;
  assign bus.BUSY = busy;
  always_comb begin
    cmd_d = cmd_q;
    bsy_d = bsy_q;
    addr_d = addr_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    wel_d = wel_q;
    q_d = q_q;
    qv_d = 1'b0;
    wrote_d = wrote_q;
    pp_d = pp_q;
    be_d = be_q;
    we = 1'b0;
    wa = addr_q;
    wd = rd & bus.D;
    // busy engine runs independently of chip select so RDSR can poll it
    if (bsy_q == PROG_WAIT) begin
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == '0) begin
        bsy_d = IDLE;
        wel_d = 1'b0;
      end
    end else if (bsy_q == ERASE) begin
      we = 1'b1;
      wa = cnt_q[AW-1:0];
      wd = 8'hFF;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q[AW-1:0] == '1) begin
        bsy_d = IDLE;
        wel_d = 1'b0;
      end
    end
    if (bus.S) begin
      cmd_d = IDLE;
      if (cmd_q == PROG_DATA && wrote_q) begin
        bsy_d = PROG_WAIT;
        cnt_d = CW'(PROG_CYCLES - 1);
      end
      // be_q survives only if nothing followed the BE opcode
      if (cmd_q == IGNORE && be_q) begin
        bsy_d = ERASE;
        cnt_d = '0;
      end
    end else begin
      case (cmd_q)
        IDLE, OPCODE: begin
          cmd_d = OPCODE;
          if (acc) begin
            cmd_d = IGNORE;
            addr_d = '0;
            idx_d = '0;
            wrote_d = 1'b0;
            be_d = 1'b0;
            if (bus.D == 8'h05) cmd_d = STATUS;
            else if (!busy) begin
              case (bus.D)
                8'h06: wel_d = 1'b1;
                8'h04: wel_d = 1'b0;
                8'h9F: cmd_d = ID;
                8'h03: begin
                  cmd_d = ADDR;
                  pp_d = 1'b0;
                end
                8'h02: if (wel_q && bus.W_ENABLE) begin
                  cmd_d = ADDR;
                  pp_d = 1'b1;
                end
                8'hC7: be_d = wel_q && bus.W_ENABLE;
                default: ;
              endcase
            end
          end
        end
        ADDR: if (acc) begin
          addr_d = AW'({addr_q, bus.D});
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'(ADDR_BYTES - 1)) cmd_d = pp_q ? PROG_DATA : READ_DATA;
        end
        READ_DATA: if (acc) begin
          q_d = rd;
          qv_d = 1'b1;
          addr_d = addr_q + 1'b1;
        end
        PROG_DATA: if (acc) begin
          we = 1'b1;
          wrote_d = 1'b1;
          addr_d = (addr_q & ~PMASK) | ((addr_q + 1'b1) & PMASK);
        end
        STATUS: if (acc) begin
          q_d = {6'b0, wel_q, busy};
          qv_d = 1'b1;
        end
        ID: if (acc) begin
          q_d = idx_q == 2'd0 ? JEDEC_ID[23:16] : idx_q == 2'd1 ? JEDEC_ID[15:8] :
                idx_q == 2'd2 ? JEDEC_ID[7:0] : 8'h00;
          qv_d = 1'b1;
          idx_d = idx_q == 2'd3 ? idx_q : idx_q + 2'd1;
        end
        IGNORE: if (acc) be_d = 1'b0;
        default: ;
      endcase
    end
  end
  always_ff @(posedge SCK or negedge RESET) begin
    if (!RESET) begin
      cmd_q <= IDLE;
      bsy_q <= IDLE;
      addr_q <= '0;
      cnt_q <= '0;
      idx_q <= '0;
      wel_q <= 1'b0;
      q_q <= 8'h00;
      qv_q <= 1'b0;
      wrote_q <= 1'b0;
      pp_q <= 1'b0;
      be_q <= 1'b0;
    end else begin
      cmd_q <= cmd_d;
      bsy_q <= bsy_d;
      addr_q <= addr_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      wel_q <= wel_d;
      q_q <= q_d;
      qv_q <= qv_d;
      wrote_q <= wrote_d;
      pp_q <= pp_d;
      be_q <= be_d;
    end
  end
  // array contents deliberately survive reset
  always_ff @(posedge SCK) begin
    if (we) mem[wa] <= wd;
  end
endmodule

// File: tb/tb_flash_spi_mem_ctrl.sv
// tb_flash_spi_mem_ctrl: randomized self-checking bench with a byte-array flash model
module tb_flash_spi_mem_ctrl;
  logic SCK = 1'b0;
  logic RESET = 1'b0;
  flash_spi_mem_ctrl_if bus();
  flash_spi_mem_ctrl dut (.SCK(SCK), .RESET(RESET), .bus(bus));
  always #5 SCK = ~SCK;
  int n_chk = 0, n_fail = 0, run = 0, last_run = 0;
  logic [7:0] mem_m [4096];
  bit wel_m = 1'b0;
  logic [7:0] tx[$], rx[$];
  logic rv[$];
  // length of the most recently completed BUSY pulse
  always @(negedge SCK) begin
    if (bus.BUSY === 1'b1) run++;
    else begin
      if (run != 0) last_run = run;
      run = 0;
    end
  end
  task automatic xfer(input logic [7:0] b, output logic [7:0] q, output logic v);
    @(negedge SCK);
    bus.D = b;
    bus.DATA_DONE = 1'b1;
    @(negedge SCK);
    bus.DATA_DONE = 1'b0;
    q = bus.Q;
    v = bus.Q_VALID;
  endtask
  task automatic txn();
    logic [7:0] q;
    logic v;
    rx.delete();
    rv.delete();
    @(negedge SCK) bus.S = 1'b0;
    foreach (tx[i]) begin
      xfer(tx[i], q, v);
      rx.push_back(q);
      rv.push_back(v);
    end
    @(negedge SCK) bus.S = 1'b1;
    @(negedge SCK);
  endtask
  task automatic mk(input logic [7:0] op, input logic [23:0] a, input int na, input int nd);
    tx.delete();
    tx.push_back(op);
    if (na != 0) begin
      tx.push_back(a[23:16]);
      tx.push_back(a[15:8]);
      tx.push_back(a[7:0]);
    end
    for (int i = 0; i < nd; i++) tx.push_back(8'($urandom));
  endtask
  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 6000 && !ok; i++) begin
      @(negedge SCK);
      ok = (bus.BUSY === 1'b0);
    end
    @(negedge SCK);
  endtask
  // flash program: AND each data byte in, address wraps inside a 256-byte page
  function automatic void m_pp(input logic [23:0] a);
    int p = int'(a[11:0]);
    for (int i = 4; i < tx.size(); i++) begin
      mem_m[p] = mem_m[p] & tx[i];
      p = (p / 256) * 256 + (p + 1) % 256;
    end
    if (tx.size() > 4) wel_m = 1'b0;
  endfunction
  function automatic int ma(input logic [23:0] a, input int i);
    return (int'(a[11:0]) + i) % 4096;
  endfunction
  task automatic test_reset();
    repeat (3) @(negedge SCK);
    n_chk++;
    if ({bus.Q, bus.Q_VALID, bus.BUSY} !== 10'h000) begin
      n_fail++;
      $display("FAIL reset_hold: got Q=%h V=%b B=%b expected 00 0 0", bus.Q, bus.Q_VALID, bus.BUSY);
    end
    @(negedge SCK) RESET = 1'b1;
    @(negedge SCK);
    mk(8'h05, 0, 0, 2);
    txn();
    n_chk++;
    if (rv[0] !== 1'b0 || rx[1] !== 8'h00 || rv[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_rdsr: got %h/%b (op valid %b) expected 00/1", rx[1], rv[1], rv[0]);
    end
  endtask
  task automatic test_rdid();
    logic [7:0] exp [4];
    logic [7:0] q;
    logic v;
    exp = '{8'h20, 8'hBA, 8'h16, 8'h00};
    @(negedge SCK) bus.S = 1'b0;
    xfer(8'h9F, q, v);
    n_chk++;
    if (v !== 1'b0) begin
      n_fail++;
      $display("FAIL rdid_opcode_valid: got %b expected 0", v);
    end
    for (int k = 0; k < 4; k++) begin
      xfer(8'($urandom), q, v);
      n_chk++;
      if (q !== exp[k] || v !== 1'b1) begin
        n_fail++;
        $display("FAIL rdid_byte%0d: got %h/%b expected %h/1", k, q, v, exp[k]);
      end
      @(negedge SCK);
      n_chk++;
      if (bus.Q_VALID !== 1'b0 || bus.Q !== exp[k]) begin
        n_fail++;
        $display("FAIL rdid_pulse%0d: got %h/%b expected %h/0", k, bus.Q, bus.Q_VALID, exp[k]);
      end
    end
    @(negedge SCK) bus.S = 1'b1;
    @(negedge SCK);
  endtask
  task automatic test_erase();
    bit ok;
    logic [23:0] a;
    mk(8'h06, 0, 0, 0);
    txn();
    mk(8'hC7, 0, 0, 0);
    txn();
    wait_idle(ok);
    foreach (mem_m[i]) mem_m[i] = 8'hFF;
    n_chk++;
    if (!ok || last_run != 4096) begin
      n_fail++;
      $display("FAIL erase_busy_len: got %0d (idle %b) expected 4096", last_run, ok);
    end
    mk(8'h05, 0, 0, 1);
    txn();
    n_chk++;
    if (rx[1] !== 8'h00 || rv[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL erase_rdsr: got %h/%b expected 00/1", rx[1], rv[1]);
    end
    a = 24'h000FFF;
    mk(8'h03, a, 1, 1);
    txn();
    n_chk++;
    if (rx[4] !== mem_m[ma(a, 0)] || rv[4] !== 1'b1) begin
      n_fail++;
      $display("FAIL erase_read_fff: got %h/%b expected %h/1", rx[4], rv[4], mem_m[ma(a, 0)]);
    end
  endtask
  task automatic test_pp();
    logic [7:0] q;
    logic v;
    bit ok;
    mk(8'h06, 0, 0, 0);
    txn();
    wel_m = 1'b1;
    mk(8'h02, 24'h000010, 1, 0);
    tx.push_back(8'h5A);
    tx.push_back(8'h3C);
    txn();
    @(negedge SCK) bus.S = 1'b0;
    xfer(8'h05, q, v);
    xfer(8'h00, q, v);
    n_chk++;
    if (q !== {6'b0, wel_m, 1'b1} || v !== 1'b1) begin
      n_fail++;
      $display("FAIL pp_rdsr_busy: got %h/%b expected 03/1", q, v);
    end
    m_pp(24'h000010);
    wait_idle(ok);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL pp_idle_timeout: BUSY still %b", bus.BUSY);
    end
    xfer(8'h00, q, v);
    n_chk++;
    if (q !== {6'b0, wel_m, 1'b0} || v !== 1'b1) begin
      n_fail++;
      $display("FAIL pp_rdsr_done: got %h/%b expected 00/1", q, v);
    end
    @(negedge SCK) bus.S = 1'b1;
    @(negedge SCK);
    n_chk++;
    if (last_run != 16) begin
      n_fail++;
      $display("FAIL pp_busy_len: got %0d expected 16", last_run);
    end
    mk(8'h03, 24'h000010, 1, 2);
    txn();
    for (int i = 0; i < 2; i++) begin
      n_chk++;
      if (rx[4+i] !== mem_m[ma(24'h10, i)] || rv[4+i] !== 1'b1) begin
        n_fail++;
        $display("FAIL pp_read%0d: got %h/%b expected %h/1", i, rx[4+i], rv[4+i], mem_m[ma(24'h10, i)]);
      end
    end
  endtask
  task automatic test_page_wrap();
    bit ok;
    logic [23:0] a;
    for (int r = 0; r < 2; r++) begin
      mk(8'h06, 0, 0, 0);
      txn();
      wel_m = 1'b1;
      mk(8'h02, 24'h0000FE, 1, 0);
      tx.push_back(r == 0 ? 8'h5A : 8'hF0);
      if (r == 0) begin
        tx.push_back(8'($urandom));
        tx.push_back(8'($urandom));
      end
      txn();
      m_pp(24'h0000FE);
      wait_idle(ok);
      foreach (tx[i]) if (i == 4) a = 24'h0000FE;
      mk(8'h03, 24'h0000FE, 1, 3);
      txn();
      for (int i = 0; i < 3; i++) begin
        n_chk++;
        if (!ok || rx[4+i] !== mem_m[ma(a, i)] || rv[4+i] !== 1'b1) begin
          n_fail++;
          $display("FAIL page_wrap_r%0d_b%0d: got %h/%b expected %h/1", r, i, rx[4+i], rv[4+i], mem_m[ma(a, i)]);
        end
      end
    end
    mk(8'h03, 24'h000000, 1, 1);
    txn();
    n_chk++;
    if (rx[4] !== mem_m[0] || rv[4] !== 1'b1) begin
      n_fail++;
      $display("FAIL page_wrap_000: got %h/%b expected %h/1", rx[4], rv[4], mem_m[0]);
    end
    mk(8'h03, 24'h000100, 1, 1);
    txn();
    n_chk++;
    if (rx[4] !== mem_m[256] || rv[4] !== 1'b1) begin
      n_fail++;
      $display("FAIL page_wrap_100: got %h/%b expected %h/1", rx[4], rv[4], mem_m[256]);
    end
  endtask
  task automatic test_random_pp();
    bit ok;
    logic [23:0] a;
    int n;
    for (int r = 0; r < 6; r++) begin
      a = 24'($urandom);
      n = int'($urandom_range(1, 5));
      mk(8'h06, 0, 0, 0);
      txn();
      wel_m = 1'b1;
      mk(8'h02, a, 1, n);
      txn();
      m_pp(a);
      wait_idle(ok);
      n_chk++;
      if (!ok || last_run != 16) begin
        n_fail++;
        $display("FAIL rand_pp%0d_busy: got %0d (idle %b) expected 16", r, last_run, ok);
      end
      mk(8'h03, a, 1, n);
      txn();
      for (int i = 0; i < n; i++) begin
        n_chk++;
        if (rx[4+i] !== mem_m[ma(a, i)] || rv[4+i] !== 1'b1) begin
          n_fail++;
          $display("FAIL rand_pp%0d_b%0d: got %h/%b expected %h/1", r, i, rx[4+i], rv[4+i], mem_m[ma(a, i)]);
        end
      end
    end
  endtask
  task automatic test_wp();
    int lr;
    logic [23:0] a;
    lr = last_run;
    bus.W_ENABLE = 1'b0;
    mk(8'h06, 0, 0, 0);
    txn();
    wel_m = 1'b1;
    mk(8'hC7, 0, 0, 0);
    txn();
    repeat (4) @(negedge SCK);
    n_chk++;
    if (bus.BUSY !== 1'b0 || last_run != lr) begin
      n_fail++;
      $display("FAIL wp_be: got BUSY=%b run=%0d expected 0 %0d", bus.BUSY, last_run, lr);
    end
    a = 24'($urandom);
    mk(8'h02, a, 1, 0);
    tx.push_back(8'h00);
    txn();
    repeat (2) @(negedge SCK);
    mk(8'h03, a, 1, 1);
    txn();
    n_chk++;
    if (rx[4] !== mem_m[ma(a, 0)] || rv[4] !== 1'b1) begin
      n_fail++;
      $display("FAIL wp_pp_blocked: got %h/%b expected %h/1", rx[4], rv[4], mem_m[ma(a, 0)]);
    end
    mk(8'h05, 0, 0, 1);
    txn();
    n_chk++;
    if (rx[1] !== {6'b0, wel_m, 1'b0}) begin
      n_fail++;
      $display("FAIL wp_wel_kept: got %h expected 02", rx[1]);
    end
    bus.W_ENABLE = 1'b1;
    mk(8'h04, 0, 0, 0);
    txn();
    wel_m = 1'b0;
    mk(8'h05, 0, 0, 1);
    txn();
    n_chk++;
    if (rx[1] !== {6'b0, wel_m, 1'b0}) begin
      n_fail++;
      $display("FAIL wrdi_rdsr: got %h expected 00", rx[1]);
    end
  endtask
  task automatic test_no_data();
    mk(8'h06, 0, 0, 0);
    txn();
    wel_m = 1'b1;
    mk(8'h02, 24'($urandom), 1, 0);
    txn();
    repeat (3) @(negedge SCK);
    mk(8'h05, 0, 0, 1);
    txn();
    n_chk++;
    if (bus.BUSY !== 1'b0 || rx[1] !== {6'b0, wel_m, 1'b0}) begin
      n_fail++;
      $display("FAIL pp_zero_data: got BUSY=%b SR=%h expected 0 02", bus.BUSY, rx[1]);
    end
    mk(8'hC7, 0, 0, 1);
    txn();
    repeat (3) @(negedge SCK);
    mk(8'h03, 24'h000010, 1, 1);
    txn();
    n_chk++;
    if (bus.BUSY !== 1'b0 || rx[4] !== mem_m[16]) begin
      n_fail++;
      $display("FAIL be_extra_byte: got BUSY=%b mem=%h expected 0 %h", bus.BUSY, rx[4], mem_m[16]);
    end
    mk(8'h04, 0, 0, 0);
    txn();
    wel_m = 1'b0;
  endtask
  task automatic test_read_wrap();
    mk(8'h03, 24'h000FFF, 1, 2);
    txn();
    for (int i = 0; i < 2; i++) begin
      n_chk++;
      if (rx[4+i] !== mem_m[ma(24'hFFF, i)] || rv[4+i] !== 1'b1) begin
        n_fail++;
        $display("FAIL read_wrap%0d: got %h/%b expected %h/1", i, rx[4+i], rv[4+i], mem_m[ma(24'hFFF, i)]);
      end
    end
  endtask
  task automatic test_busy_lockout();
    bit ok;
    logic [23:0] a;
    mk(8'h06, 0, 0, 0);
    txn();
    wel_m = 1'b1;
    mk(8'hC7, 0, 0, 0);
    txn();
    mk(8'h9F, 0, 0, 3);
    txn();
    n_chk++;
    if (rv.sum() with (int'(item)) != 0) begin
      n_fail++;
      $display("FAIL busy_rdid: got %0d valid pulses expected 0", rv.sum() with (int'(item)));
    end
    mk(8'h03, 24'($urandom), 1, 2);
    txn();
    n_chk++;
    if (rv.sum() with (int'(item)) != 0) begin
      n_fail++;
      $display("FAIL busy_read: got %0d valid pulses expected 0", rv.sum() with (int'(item)));
    end
    mk(8'h04, 0, 0, 0);
    txn();
    mk(8'h05, 0, 0, 1);
    txn();
    n_chk++;
    if (rx[1] !== {6'b0, wel_m, 1'b1} || rv[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_rdsr: got %h/%b expected 03/1", rx[1], rv[1]);
    end
    wait_idle(ok);
    foreach (mem_m[i]) mem_m[i] = 8'hFF;
    wel_m = 1'b0;
    n_chk++;
    if (!ok || last_run != 4096) begin
      n_fail++;
      $display("FAIL busy_erase_len: got %0d (idle %b) expected 4096", last_run, ok);
    end
    a = 24'($urandom);
    mk(8'h03, a, 1, 3);
    txn();
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (rx[4+i] !== mem_m[ma(a, i)]) begin
        n_fail++;
        $display("FAIL erase2_read%0d: got %h expected %h", i, rx[4+i], mem_m[ma(a, i)]);
      end
    end
  endtask
  task automatic test_reset_abort();
    logic [23:0] a;
    a = 24'($urandom);
    mk(8'h06, 0, 0, 0);
    txn();
    mk(8'h02, a, 1, 2);
    txn();
    m_pp(a);
    repeat (4) @(negedge SCK);
    n_chk++;
    if (bus.BUSY !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_busy_before: got %b expected 1", bus.BUSY);
    end
    #1 RESET = 1'b0;
    #1;
    n_chk++;
    if ({bus.Q, bus.Q_VALID, bus.BUSY} !== 10'h000) begin
      n_fail++;
      $display("FAIL abort_reset: got Q=%h V=%b B=%b expected 00 0 0", bus.Q, bus.Q_VALID, bus.BUSY);
    end
    wel_m = 1'b0;
    @(negedge SCK) RESET = 1'b1;
    @(negedge SCK);
    mk(8'h05, 0, 0, 1);
    txn();
    n_chk++;
    if (rx[1] !== {6'b0, wel_m, 1'b0} || rv[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_rdsr: got %h/%b expected 00/1", rx[1], rv[1]);
    end
    mk(8'h03, a, 1, 2);
    txn();
    for (int i = 0; i < 2; i++) begin
      n_chk++;
      if (rx[4+i] !== mem_m[ma(a, i)]) begin
        n_fail++;
        $display("FAIL abort_kept%0d: got %h expected %h", i, rx[4+i], mem_m[ma(a, i)]);
      end
    end
  endtask
  initial begin
    bus.S = 1'b1;
    bus.W_ENABLE = 1'b1;
    bus.D = 8'h00;
    bus.DATA_DONE = 1'b0;
    test_reset();
    test_rdid();
    test_erase();
    test_pp();
    test_page_wrap();
    test_random_pp();
    test_wp();
    test_no_data();
    test_read_wrap();
    test_busy_lockout();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
